// File: rtl/spi_reg_ctrl.sv
// Command sequencer between a byte-level SPI slave and a small register bank.
// Parses chip-select framed command/data bytes, executes reads/writes and schedules tx loads.
module spi_reg_ctrl #(
  parameter int         ADDR_W         = 4,
  parameter logic [7:0] SYNC_MARK      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       i_clk,
  input  logic       i_sys_rst,
  input  logic       i_cs,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_rdy,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_rdy,
  input  logic [7:0] i_status,
  output logic [7:0] o_reg0,
  output logic [7:0] o_reg1,
  output logic       o_busy,
  output logic       o_cmd_err
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam int NUM_RW   = NUM_REGS - 2;
  localparam logic [ADDR_W-1:0] ERR_ADDR  = ADDR_W'(NUM_REGS - 2);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_DISC = 3'd4;

  logic              cs_meta_r, cs_sync_r, cs_prev_r;
  logic [2:0]        state_r, state_sel_s, state_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic              ai_r, ai_nxt_s;
  logic [7:0]        bank_r [0:NUM_RW-1];
  logic [7:0]        err_cnt_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [7:0]        tx_byte_r, rd_data_s;
  logic              tx_rdy_r, pend_r, busy_r, cmd_err_r;
  logic              frame_start_s, frame_end_s, active_s, timeout_s;
  logic              wr_en_s, err_evt_s, load_req_s, sync_load_s;

  // Sync flops reset low so a frame already in progress at reset release never shows a start edge.
  always_ff @(posedge i_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      cs_meta_r <= 1'b0;
      cs_sync_r <= 1'b0;
      cs_prev_r <= 1'b0;
    end else begin
      cs_meta_r <= i_cs;
      cs_sync_r <= cs_meta_r;
      cs_prev_r <= cs_sync_r;
    end
  end

  always_comb begin
    frame_start_s = cs_prev_r & ~cs_sync_r;
    frame_end_s   = ~cs_prev_r & cs_sync_r;
    active_s      = (state_r == ST_CMD) || (state_r == ST_WR) || (state_r == ST_RD);
    timeout_s     = active_s && !i_rx_rdy && (to_cnt_r == TO_LAST);
  end

  // Frame sequencing; a byte arriving with the frame end is still processed before IDLE.
  always_comb begin
    state_sel_s = state_r;
    addr_nxt_s  = addr_r;
    ai_nxt_s    = ai_r;
    wr_en_s     = 1'b0;
    err_evt_s   = 1'b0;
    load_req_s  = 1'b0;
    sync_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frame_start_s) begin
          state_sel_s = ST_CMD;
          sync_load_s = 1'b1;
        end else begin
          state_sel_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (i_rx_rdy) begin
          addr_nxt_s = i_rx_byte[ADDR_W-1:0];
          ai_nxt_s   = i_rx_byte[6];
          if (i_rx_byte[5:4] != 2'b00) begin
            err_evt_s   = 1'b1;
            state_sel_s = ST_DISC;
          end else if (i_rx_byte[7]) begin
            load_req_s  = 1'b1;
            state_sel_s = ST_RD;
          end else begin
            state_sel_s = ST_WR;
          end
        end else if (timeout_s) begin
          err_evt_s   = 1'b1;
          state_sel_s = ST_DISC;
        end else begin
          state_sel_s = ST_CMD;
        end
      end
      ST_WR: begin
        if (i_rx_rdy) begin
          wr_en_s    = 1'b1;
          addr_nxt_s = ai_r ? addr_r + ADDR_W'(1) : addr_r;
        end else if (timeout_s) begin
          err_evt_s   = 1'b1;
          state_sel_s = ST_DISC;
        end else begin
          state_sel_s = ST_WR;
        end
      end
      ST_RD: begin
        if (i_rx_rdy) begin
          load_req_s = 1'b1;
          addr_nxt_s = ai_r ? addr_r + ADDR_W'(1) : addr_r;
        end else if (timeout_s) begin
          err_evt_s   = 1'b1;
          state_sel_s = ST_DISC;
        end else begin
          state_sel_s = ST_RD;
        end
      end
      ST_DISC: state_sel_s = ST_DISC;
      default: state_sel_s = ST_IDLE;
    endcase
    state_nxt_s = frame_end_s ? ST_IDLE : state_sel_s;
  end

  always_comb begin
    if (addr_nxt_s == STAT_ADDR) begin
      rd_data_s = i_status;
    end else if (addr_nxt_s == ERR_ADDR) begin
      rd_data_s = err_cnt_r;
    end else begin
      rd_data_s = bank_r[addr_nxt_s];
    end
  end

  always_ff @(posedge i_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_r   <= ST_IDLE;
      addr_r    <= '0;
      ai_r      <= 1'b0;
      busy_r    <= 1'b0;
      cmd_err_r <= 1'b0;
      to_cnt_r  <= '0;
    end else begin
      state_r   <= state_nxt_s;
      addr_r    <= addr_nxt_s;
      ai_r      <= ai_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      cmd_err_r <= err_evt_s;
      if (!active_s || i_rx_rdy) begin
        to_cnt_r <= '0;
      end else if (to_cnt_r != TO_LAST) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
    end
  end

  // Error counter saturates; any write to its address clears it.
  always_ff @(posedge i_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      err_cnt_r <= 8'h00;
    end else if (err_evt_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else if (wr_en_s && (addr_r == ERR_ADDR)) begin
      err_cnt_r <= 8'h00;
    end
  end

  always_ff @(posedge i_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      for (int i = 0; i < NUM_RW; i++) bank_r[i] <= 8'h00;
    end else if (wr_en_s && (addr_r < ERR_ADDR)) begin
      bank_r[addr_r] <= i_rx_byte;
    end
  end

  // A load requested while the strobe is still high is deferred one cycle.
  always_ff @(posedge i_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      tx_byte_r <= 8'h00;
      tx_rdy_r  <= 1'b0;
      pend_r    <= 1'b0;
    end else if (sync_load_s) begin
      tx_byte_r <= SYNC_MARK;
      tx_rdy_r  <= 1'b1;
      pend_r    <= 1'b0;
    end else if ((load_req_s || pend_r) && !tx_rdy_r) begin
      tx_byte_r <= rd_data_s;
      tx_rdy_r  <= 1'b1;
      pend_r    <= 1'b0;
    end else begin
      tx_rdy_r  <= 1'b0;
      pend_r    <= load_req_s | pend_r;
    end
  end

  assign o_tx_byte = tx_byte_r;
  assign o_tx_rdy  = tx_rdy_r;
  assign o_reg0    = bank_r[0];
  assign o_reg1    = bank_r[1];
  assign o_busy    = busy_r;
  assign o_cmd_err = cmd_err_r;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed scenarios plus random frames
// compared against a transaction-level register model.
module tb_spi_reg_ctrl;
  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         TIMEOUT = 1024;

  logic       i_clk = 1'b0;
  logic       i_sys_rst, i_cs, i_rx_rdy;
  logic [7:0] i_rx_byte, i_status;
  logic [7:0] o_tx_byte, o_reg0, o_reg1;
  logic       o_tx_rdy, o_busy, o_cmd_err;

  int         n_checks = 0;
  int         n_fail = 0;
  int         exp_err_pulses = 0;
  int         err_seen = 0;
  logic [7:0] m_reg [0:13];
  logic [7:0] m_err;
  logic [7:0] exp_q [$];
  logic [7:0] dq [$];
  logic       tx_prev = 1'b0;

  spi_reg_ctrl dut (
    .i_clk     (i_clk),
    .i_sys_rst (i_sys_rst),
    .i_cs      (i_cs),
    .i_rx_byte (i_rx_byte),
    .i_rx_rdy  (i_rx_rdy),
    .o_tx_byte (o_tx_byte),
    .o_tx_rdy  (o_tx_rdy),
    .i_status  (i_status),
    .o_reg0    (o_reg0),
    .o_reg1    (o_reg1),
    .o_busy    (o_busy),
    .o_cmd_err (o_cmd_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every tx load is matched against the next expected byte.
  always @(negedge i_clk) begin
    if (o_cmd_err) err_seen <= err_seen + 1;
    if (o_tx_rdy) begin
      check_val("tx_consec", 32'(tx_prev), 32'd0);
      if (exp_q.size() == 0) check_val("tx_unexpected", 32'(o_tx_byte), 32'h100);
      else check_val("tx_byte", 32'(o_tx_byte), 32'(exp_q.pop_front()));
    end
    tx_prev <= o_tx_rdy;
  end

  function automatic logic [7:0] m_read(input logic [3:0] a);
    if (a == 4'd15) return i_status;
    else if (a == 4'd14) return m_err;
    else return m_reg[a];
  endfunction

  task automatic m_write(input logic [3:0] a, input logic [7:0] d);
    if (a < 4'd14) m_reg[a] = d;
    else if (a == 4'd14) m_err = 8'h00;
  endtask

  task automatic m_error();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
    exp_err_pulses++;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 14; i++) m_reg[i] = 8'h00;
    m_err = 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_byte = b;
    i_rx_rdy  = 1'b1;
    @(negedge i_clk);
    i_rx_rdy  = 1'b0;
  endtask

  task automatic start_frame();
    exp_q.push_back(SYNC);
    i_cs = 1'b0;
    tick(4);
    check_val("busy_start", 32'(o_busy), 32'd1);
    check_val("sync_loaded", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic end_frame();
    tick(2);
    i_cs = 1'b1;
    tick(4);
    check_val("busy_end", 32'(o_busy), 32'd0);
  endtask

  // One framed transaction: command byte then the bytes queued in dq.
  task automatic do_txn(input logic [7:0] cmd, input logic [7:0] status);
    logic [3:0] a;
    logic [7:0] d;
    logic       bad, rd;
    bad = (cmd[5:4] != 2'b00);
    rd  = cmd[7];
    a   = cmd[3:0];
    i_status = status;
    start_frame();
    if (bad) m_error();
    else if (rd) exp_q.push_back(m_read(a));
    send_byte(cmd);
    if (!bad && rd) check_val("rd_latency", 32'(o_tx_rdy), 32'd1);
    while (dq.size() > 0) begin
      d = dq.pop_front();
      tick($urandom_range(3, 6));
      if (bad) begin
        send_byte(d);
      end else if (rd) begin
        if (cmd[6]) a = a + 4'd1;
        exp_q.push_back(m_read(a));
        send_byte(d);
        check_val("rd_latency", 32'(o_tx_rdy), 32'd1);
      end else begin
        m_write(a, d);
        send_byte(d);
        if (a == 4'd0) check_val("wr_vis0", 32'(o_reg0), 32'(m_reg[0]));
        else if (a == 4'd1) check_val("wr_vis1", 32'(o_reg1), 32'(m_reg[1]));
        if (cmd[6]) a = a + 4'd1;
      end
    end
    end_frame();
    check_val("tx_all_loaded", 32'(exp_q.size()), 32'd0);
    check_val("reg0", 32'(o_reg0), 32'(m_reg[0]));
    check_val("reg1", 32'(o_reg1), 32'(m_reg[1]));
    check_val("err_pulses", 32'(err_seen), 32'(exp_err_pulses));
  endtask

  initial begin
    int hit;
    i_sys_rst = 1'b0;
    i_cs      = 1'b1;
    i_rx_rdy  = 1'b0;
    i_rx_byte = 8'h00;
    i_status  = 8'h00;
    m_clear();
    tick(3);
    check_val("rst_tx_byte", 32'(o_tx_byte), 32'd0);
    check_val("rst_tx_rdy", 32'(o_tx_rdy), 32'd0);
    check_val("rst_reg0", 32'(o_reg0), 32'd0);
    check_val("rst_reg1", 32'(o_reg1), 32'd0);
    check_val("rst_busy", 32'(o_busy), 32'd0);
    check_val("rst_cmd_err", 32'(o_cmd_err), 32'd0);
    i_sys_rst = 1'b1;
    tick(4);

    start_frame();
    end_frame();

    dq = '{8'h11, 8'h22}; do_txn(8'h41, 8'h00);
    dq.delete();          do_txn(8'h82, 8'h00);
    dq = '{8'h33, 8'h44}; do_txn(8'h01, 8'h00);
    check_val("reg1_no_ai", 32'(o_reg1), 32'h44);

    dq = '{8'h10, 8'h20, 8'h30}; do_txn(8'h40, 8'h00);
    dq = '{8'hFF, 8'hFF};        do_txn(8'hC0, 8'h00);

    dq = '{8'h55, 8'h66}; do_txn(8'h30, 8'h00);
    dq.delete();          do_txn(8'h8E, 8'h00);
    dq = '{8'h00};        do_txn(8'h0E, 8'h00);
    dq.delete();          do_txn(8'h8E, 8'h00);

    for (int k = 0; k < 300; k++) begin
      dq.delete();
      do_txn(8'h30, 8'h00);
    end
    dq.delete(); do_txn(8'h8E, 8'h00);

    dq = '{8'hAB, 8'hCD, 8'hEF}; do_txn(8'h4D, 8'h00);
    dq.delete(); do_txn(8'h8E, 8'h00);
    dq.delete(); do_txn(8'h8D, 8'h00);
    dq.delete(); do_txn(8'h8F, 8'h5C);

    // Timeout: command then silence.
    i_status = 8'h00;
    start_frame();
    send_byte(8'h02);
    hit = 0;
    for (int k = 1; k <= 1200 && hit == 0; k++) begin
      @(negedge i_clk);
      if (o_cmd_err) hit = k;
    end
    m_error();
    check_val("timeout_cycle_ok", 32'((hit >= TIMEOUT - 2) && (hit <= TIMEOUT + 2)), 32'd1);
    check_val("busy_discard", 32'(o_busy), 32'd1);
    tick(4);
    send_byte(8'h99);
    end_frame();
    check_val("err_pulses_to", 32'(err_seen), 32'(exp_err_pulses));
    dq.delete(); do_txn(8'h82, 8'h00);

    for (int t = 0; t < 60; t++) begin
      logic [7:0] c;
      int nb;
      c = 8'($urandom);
      if ($urandom_range(0, 9) != 0) c[5:4] = 2'b00;
      nb = $urandom_range(0, 4);
      dq.delete();
      for (int j = 0; j < nb; j++) dq.push_back(8'($urandom));
      do_txn(c, 8'($urandom));
    end

    // Reset in the middle of a write frame.
    i_status = 8'h00;
    start_frame();
    send_byte(8'h40);
    tick(3);
    send_byte(8'h77);
    m_write(4'd0, 8'h77);
    check_val("pre_rst_reg0", 32'(o_reg0), 32'h77);
    tick(2);
    i_sys_rst = 1'b0;
    #1;
    check_val("mid_rst_tx_byte", 32'(o_tx_byte), 32'd0);
    check_val("mid_rst_tx_rdy", 32'(o_tx_rdy), 32'd0);
    check_val("mid_rst_reg0", 32'(o_reg0), 32'd0);
    check_val("mid_rst_reg1", 32'(o_reg1), 32'd0);
    check_val("mid_rst_busy", 32'(o_busy), 32'd0);
    check_val("mid_rst_cmd_err", 32'(o_cmd_err), 32'd0);
    m_clear();
    exp_q.delete();
    tick(3);
    i_sys_rst = 1'b1;
    tick(4);
    send_byte(8'h55);
    tick(3);
    send_byte(8'h66);
    tick(2);
    check_val("post_rst_reg0", 32'(o_reg0), 32'd0);
    check_val("post_rst_busy", 32'(o_busy), 32'd0);
    i_cs = 1'b1;
    tick(4);
    dq = '{8'h00}; do_txn(8'hC0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
